stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 121 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: two-flop synchronisers, per-button debouncers and a
// start/pause/clear FSM driving the counter's run level and clear pulse.
module stopwatch_ctrl #(
   parameter int unsigned DB_COUNT = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_clear,
   output logic       start,
   output logic       clear,
   output logic [1:0] state
);

   localparam int unsigned CNT_W = (DB_COUNT < 2) ? 1 : $clog2(DB_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

   // Bit 0 is the start button, bit 1 the clear button.
   localparam int unsigned BTN_START = 0;
   localparam int unsigned BTN_CLEAR = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10
   } state_e;

   logic [1:0]            btn_raw;
   logic [1:0]            sync1_q, sync1_d;
   logic [1:0]            sync2_q, sync2_d;
   logic [1:0]            db_q, db_d;
   logic [1:0]            db_prev_q, db_prev_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            press;
   logic                  press_start;
   logic                  press_clear;
   state_e                state_q, state_d;
   logic                  clear_q, clear_d;

   assign btn_raw = {btn_clear, btn_start};

   // Synchronisers and debouncers
   always_comb begin
      sync1_d   = btn_raw;
      sync2_d   = sync1_q;
      db_d      = db_q;
      db_prev_d = db_q;
      cnt_d     = cnt_q;
      for (int unsigned i = 0; i < 2; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Rising edge of the debounced level, valid the cycle after it changes.
   assign press       = db_q & ~db_prev_q;
   assign press_start = press[BTN_START];
   assign press_clear = press[BTN_CLEAR];

   // Start/stop/clear FSM; clear wins in IDLE/PAUSED, start wins in RUNNING.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press_clear) begin
               clear_d = 1'b1;
            end else if (press_start) begin
               state_d = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            if (press_start) begin
               state_d = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (press_clear) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end else if (press_start) begin
               state_d = ST_RUNNING;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         cnt_q     <= '0;
         state_q   <= ST_IDLE;
         clear_q   <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         clear_q   <= clear_d;
      end
   end

   assign start = (state_q == ST_RUNNING);
   assign clear = clear_q;
   assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_COUNT = 4 (button response on
// the 7th rising edge after a clean raw edge).
module tb_stopwatch_ctrl;

   logic       clock;
   logic       reset;
   logic       btn_start;
   logic       btn_clear;
   logic       start;
   logic       clear;
   logic [1:0] state;

   int checks;
   int errors;

   stopwatch_ctrl #(.DB_COUNT(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_start (btn_start),
      .btn_clear (btn_clear),
      .start     (start),
      .clear     (clear),
      .state     (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic press_start_btn();
      btn_start = 1'b1;
      repeat (8) tick();
      btn_start = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (start !== 1'b0 || clear !== 1'b0 || state !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs got start=%b clear=%b state=%b exp 0 0 00", start, clear, state);
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (start !== 1'b0 || clear !== 1'b0 || state !== 2'b00) begin
         errors++;
         $display("FAIL after_reset got start=%b clear=%b state=%b exp 0 0 00", start, clear, state);
      end
   endtask

   task automatic test_start_latency();
      btn_start = 1'b1;
      repeat (6) tick();
      checks++;
      if (start !== 1'b0 || state !== 2'b00) begin
         errors++;
         $display("FAIL start_edge6 got start=%b state=%b exp 0 00", start, state);
      end
      tick();
      checks++;
      if (start !== 1'b1 || state !== 2'b01) begin
         errors++;
         $display("FAIL start_edge7 got start=%b state=%b exp 1 01", start, state);
      end
      repeat (20) tick();
      checks++;
      if (state !== 2'b01) begin
         errors++;
         $display("FAIL start_no_repeat got state=%b exp 01", state);
      end
      btn_start = 1'b0;
      repeat (10) tick();
      checks++;
      if (state !== 2'b01 || start !== 1'b1) begin
         errors++;
         $display("FAIL start_release got start=%b state=%b exp 1 01", start, state);
      end
   endtask

   task automatic test_running_clear();
      int clr_seen;
      clr_seen = 0;
      btn_clear = 1'b1;
      repeat (12) begin
         tick();
         if (clear === 1'b1 || state !== 2'b01) clr_seen++;
      end
      btn_clear = 1'b0;
      repeat (8) begin
         tick();
         if (clear === 1'b1 || state !== 2'b01) clr_seen++;
      end
      checks++;
      if (clr_seen !== 0) begin
         errors++;
         $display("FAIL running_clear_ignored got %0d bad cycles exp 0", clr_seen);
      end
      btn_start = 1'b1;
      repeat (6) tick();
      checks++;
      if (state !== 2'b01) begin
         errors++;
         $display("FAIL pause_edge6 got state=%b exp 01", state);
      end
      tick();
      checks++;
      if (state !== 2'b10 || start !== 1'b0) begin
         errors++;
         $display("FAIL pause_edge7 got start=%b state=%b exp 0 10", start, state);
      end
      btn_start = 1'b0;
      repeat (8) tick();
   endtask

   task automatic test_simultaneous();
      int early;
      int extra;
      early = 0;
      extra = 0;
      btn_start = 1'b1;
      btn_clear = 1'b1;
      repeat (6) begin
         tick();
         if (clear !== 1'b0 || state !== 2'b10) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++;
         $display("FAIL simul_early got %0d bad cycles exp 0", early);
      end
      tick();
      checks++;
      if (clear !== 1'b1 || state !== 2'b00 || start !== 1'b0) begin
         errors++;
         $display("FAIL simul_edge7 got clear=%b state=%b start=%b exp 1 00 0", clear, state, start);
      end
      tick();
      checks++;
      if (clear !== 1'b0) begin
         errors++;
         $display("FAIL simul_pulse_width got clear=%b exp 0", clear);
      end
      repeat (10) begin
         tick();
         if (clear !== 1'b0) extra++;
      end
      btn_start = 1'b0;
      btn_clear = 1'b0;
      repeat (8) begin
         tick();
         if (clear !== 1'b0) extra++;
      end
      checks++;
      if (extra !== 0 || state !== 2'b00) begin
         errors++;
         $display("FAIL simul_after got extra=%0d state=%b exp 0 00", extra, state);
      end
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      repeat (5) begin
         btn_start = 1'b1;
         repeat (3) begin
            tick();
            if (start !== 1'b0 || state !== 2'b00) bad++;
         end
         btn_start = 1'b0;
         repeat (3) begin
            tick();
            if (start !== 1'b0 || state !== 2'b00) bad++;
         end
      end
      repeat (10) begin
         tick();
         if (start !== 1'b0 || state !== 2'b00) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL glitch_rejected got %0d bad cycles exp 0", bad);
      end
   endtask

   task automatic test_clear_hold();
      int pulses;
      int first_at;
      int back_to_back;
      int bad_state;
      logic prev;
      pulses = 0;
      first_at = -1;
      back_to_back = 0;
      bad_state = 0;
      prev = 1'b0;
      btn_clear = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (clear === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = i;
            if (prev === 1'b1) back_to_back++;
         end
         if (state !== 2'b00) bad_state++;
         prev = clear;
      end
      btn_clear = 1'b0;
      repeat (8) begin
         tick();
         if (clear === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL clear_hold_count got %0d exp 1", pulses);
      end
      checks++;
      if (first_at !== 7) begin
         errors++;
         $display("FAIL clear_hold_latency got %0d exp 7", first_at);
      end
      checks++;
      if (back_to_back !== 0 || bad_state !== 0) begin
         errors++;
         $display("FAIL clear_hold_shape got b2b=%0d bad_state=%0d exp 0 0", back_to_back, bad_state);
      end
   endtask

   task automatic test_async_reset();
      int bad;
      bad = 0;
      press_start_btn();
      checks++;
      if (state !== 2'b01) begin
         errors++;
         $display("FAIL async_setup got state=%b exp 01", state);
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (start !== 1'b0 || state !== 2'b00 || clear !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got start=%b state=%b clear=%b exp 0 00 0", start, state, clear);
      end
      #9 reset = 1'b1;
      repeat (10) begin
         tick();
         if (clear !== 1'b0 || state !== 2'b00) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL async_after got %0d bad cycles exp 0", bad);
      end
   endtask

   task automatic test_held_through_reset();
      btn_start = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      checks++;
      if (state !== 2'b00 || start !== 1'b0) begin
         errors++;
         $display("FAIL held_reset got start=%b state=%b exp 0 00", start, state);
      end
      #9;
      reset = 1'b1;
      repeat (6) tick();
      checks++;
      if (state !== 2'b00) begin
         errors++;
         $display("FAIL held_edge6 got state=%b exp 00", state);
      end
      tick();
      checks++;
      if (state !== 2'b01 || start !== 1'b1) begin
         errors++;
         $display("FAIL held_edge7 got start=%b state=%b exp 1 01", start, state);
      end
      btn_start = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      btn_start = 1'b0;
      btn_clear = 1'b0;
      test_reset();
      test_start_latency();
      test_running_clear();
      test_simultaneous();
      test_glitch();
      test_clear_hold();
      test_async_reset();
      do_reset();
      test_held_through_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
